// File: rtl/flash_access_arbiter.sv
// Round-robin arbiter giving two clients timed 8-bit read/write access to a parallel NOR flash.
// Owns every NF_* control line; strobes are registered and decoded from the next state.
module flash_access_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int T_RD         = 8,
  parameter int T_WP         = 4,
  parameter int RP_CYCLES    = 1500,
  parameter int BUSY_TIMEOUT = 1000000
) (
  input  logic              clk_f,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] NF_A,
  output logic [7:0]        NF_D_out,
  output logic              NF_D_oe,
  input  logic [7:0]        NF_D_in,
  output logic              NF_CE,
  output logic              NF_OE,
  output logic              NF_WE,
  output logic              NF_RP,
  output logic              NF_BYTE,
  output logic              NF_WP,
  input  logic              NF_STS
);

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    RD_ACT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_BUSY,
    ACK
  } state_t;

  // One shared phase counter, wide enough for the longest timed phase.
  localparam int MAX_AB = (T_RD > T_WP) ? T_RD : T_WP;
  localparam int MAX_CD = (RP_CYCLES > BUSY_TIMEOUT) ? RP_CYCLES : BUSY_TIMEOUT;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAXP + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] WP_LAST  = CNT_W'(T_WP - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(RP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STS_SKIP = CNT_W'(2);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic               ptr;
  logic               gnt;
  logic               grant;
  logic               to_err;
  logic               sel;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_wdata;
  logic               sts_meta;
  logic               sts_sync;

  assign NF_BYTE = 1'b0;
  assign NF_WP   = 1'b0;

  // With both requesting, ptr names the client that was not granted last.
  always_comb begin
    sel       = req1 && (!req0 || ptr);
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    to_err  = 1'b0;
    case (state)
      RST_HOLD: if (cnt >= RP_LAST) state_n = IDLE;
      IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          state_n = sel_we ? WR_SETUP : RD_ACT;
        end
      end
      RD_ACT:   if (cnt >= RD_LAST) state_n = ACK;
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: if (cnt >= WP_LAST) state_n = WR_HOLD;
      WR_HOLD:  state_n = WR_BUSY;
      WR_BUSY: begin
        // STS may lag the end of the WE pulse, so the first two cycles ignore it.
        if (cnt >= STS_SKIP && sts_sync) begin
          state_n = ACK;
        end else if (cnt >= TO_LAST) begin
          state_n = ACK;
          to_err  = 1'b1;
        end
      end
      ACK:      state_n = IDLE;
      default:  state_n = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      state <= RST_HOLD;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      sts_meta <= 1'b0;
      sts_sync <= 1'b0;
    end else begin
      sts_meta <= NF_STS;
      sts_sync <= sts_meta;
    end
  end

  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      NF_A     <= '0;
      NF_D_out <= '0;
      rdata    <= '0;
    end else begin
      if (grant) begin
        gnt      <= sel;
        ptr      <= ~sel;
        NF_A     <= sel_addr;
        NF_D_out <= sel_wdata;
      end
      if (state == RD_ACT && state_n == ACK) rdata <= NF_D_in;
    end
  end

  // Outputs follow the state being entered, so they are glitch-free flops on the pins.
  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      NF_CE   <= 1'b1;
      NF_OE   <= 1'b1;
      NF_WE   <= 1'b1;
      NF_D_oe <= 1'b0;
      NF_RP   <= 1'b0;
      busy    <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
    end else begin
      NF_CE   <= !(state_n inside {RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD});
      NF_OE   <= (state_n != RD_ACT);
      NF_WE   <= (state_n != WR_PULSE);
      NF_D_oe <= (state_n inside {WR_SETUP, WR_PULSE, WR_HOLD});
      NF_RP   <= (state_n != RST_HOLD);
      busy    <= (state_n != IDLE);
      ack0    <= (state_n == ACK) && !gnt;
      ack1    <= (state_n == ACK) && gnt;
      err     <= to_err;
    end
  end

  a_no_oe_contention: assert property (@(posedge clk_f) disable iff (rst) !(!NF_OE && NF_D_oe));
  a_no_we_during_oe:  assert property (@(posedge clk_f) disable iff (rst) !(!NF_WE && !NF_OE));
  a_ack_exclusive:    assert property (@(posedge clk_f) disable iff (rst) !(ack0 && ack1));

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Scoreboard bench for flash_access_arbiter: expected acks are queued at request time
// and retired by a monitor when the DUT pulses ack0/ack1.
module tb_flash_access_arbiter;

  localparam int ADDR_W       = 24;
  localparam int T_RD         = 3;
  localparam int T_WP         = 2;
  localparam int RP_CYCLES    = 10;
  localparam int BUSY_TIMEOUT = 20;

  logic              clk_f = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [7:0]        wdata0 = '0, wdata1 = '0;
  logic              ack0, ack1, err, busy;
  logic [7:0]        rdata;
  logic [ADDR_W-1:0] nf_a;
  logic [7:0]        nf_d_out, nf_d_in;
  logic              nf_d_oe, nf_ce, nf_oe, nf_we, nf_rp, nf_byte, nf_wp;
  logic              nf_sts = 1'b0;
  logic              use_model = 1'b0;
  logic [7:0]        flash_byte = 8'h00;

  typedef struct {
    logic       client;
    logic       is_rd;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic rr_ptr = 1'b0;

  // Flash array model: either a fixed byte or a simple address-derived pattern.
  assign nf_d_in = use_model ? (nf_a[7:0] ^ 8'h5A) : flash_byte;

  always #5 clk_f = ~clk_f;

  flash_access_arbiter #(
    .ADDR_W(ADDR_W), .T_RD(T_RD), .T_WP(T_WP),
    .RP_CYCLES(RP_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk_f(clk_f), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .NF_A(nf_a), .NF_D_out(nf_d_out), .NF_D_oe(nf_d_oe), .NF_D_in(nf_d_in),
    .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we), .NF_RP(nf_rp),
    .NF_BYTE(nf_byte), .NF_WP(nf_wp), .NF_STS(nf_sts)
  );

  always @(negedge clk_f) begin : monitor
    exp_t e;
    if (!rst && (ack0 === 1'b1 || ack1 === 1'b1)) begin
      total++;
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
        bad++;
        $display("[TB] FAIL ack_overlap: ack0=%b ack1=%b, want only one", ack0, ack1);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_ack: ack0=%b ack1=%b, want none", ack0, ack1);
      end else begin
        e = sb.pop_front();
        if (ack1 !== e.client) begin
          bad++;
          $display("[TB] FAIL ack_client: got client %b, want %b", ack1, e.client);
        end
        total++;
        if (err !== e.err) begin
          bad++;
          $display("[TB] FAIL ack_err: got %b, want %b", err, e.err);
        end
        if (e.is_rd) begin
          total++;
          if (rdata !== e.rdata) begin
            bad++;
            $display("[TB] FAIL rdata: got %h, want %h", rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic test_reset();
    logic [48:0] got;
    int hold = 0;
    int n = 0;
    logic early = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_f);
    got = {nf_ce, nf_oe, nf_we, nf_rp, nf_d_oe, ack0, ack1, err, busy, rdata, nf_a, nf_d_out};
    total++;
    if (got !== {9'b111000001, 8'h00, 24'h000000, 8'h00}) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h, want %h", got, {9'b111000001, 40'h0});
    end
    // A request raised during the RP# hold must wait for IDLE.
    rst = 1'b0;
    use_model = 1'b0;
    flash_byte = 8'h11;
    addr0 = 24'h000055;
    we0 = 1'b0;
    req0 = 1'b1;
    sb.push_back('{client: 1'b0, is_rd: 1'b1, rdata: 8'h11, err: 1'b0});
    while (nf_rp === 1'b0 && hold < 200) begin
      hold++;
      if (nf_ce !== 1'b1 || nf_a !== 24'h0) early = 1'b1;
      @(negedge clk_f);
    end
    total++;
    if (hold !== RP_CYCLES) begin
      bad++;
      $display("[TB] FAIL rp_hold: got %0d cycles, want %0d", hold, RP_CYCLES);
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("[TB] FAIL grant_during_hold: got %b, want 0", early);
    end
    while (ack0 !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk_f);
    end
    total++;
    if (ack0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL post_hold_ack: got %b, want 1", ack0);
    end
    req0 = 1'b0;
    rr_ptr = 1'b1;
    @(negedge clk_f);
  endtask

  task automatic test_read();
    int ce_low = 0, oe_low = 0, ack_at = 0;
    logic a_bad = 1'b0;
    use_model = 1'b0;
    flash_byte = 8'hA5;
    addr0 = 24'h000123;
    we0 = 1'b0;
    req0 = 1'b1;
    sb.push_back('{client: 1'b0, is_rd: 1'b1, rdata: 8'hA5, err: 1'b0});
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_f);
      if (nf_ce === 1'b0) ce_low++;
      if (nf_oe === 1'b0) oe_low++;
      if (nf_ce === 1'b0 && nf_a !== 24'h000123) a_bad = 1'b1;
      if (ack0 === 1'b1) begin
        ack_at = i;
        break;
      end
    end
    req0 = 1'b0;
    total++;
    if (ce_low !== T_RD) begin
      bad++;
      $display("[TB] FAIL read_ce_width: got %0d, want %0d", ce_low, T_RD);
    end
    total++;
    if (oe_low !== T_RD) begin
      bad++;
      $display("[TB] FAIL read_oe_width: got %0d, want %0d", oe_low, T_RD);
    end
    total++;
    if (ack_at !== T_RD + 1) begin
      bad++;
      $display("[TB] FAIL read_latency: got %0d, want %0d", ack_at, T_RD + 1);
    end
    total++;
    if (a_bad !== 1'b0) begin
      bad++;
      $display("[TB] FAIL read_addr: got bad=%b, want 0", a_bad);
    end
    flash_byte = 8'h00;
    repeat (3) @(negedge clk_f);
    total++;
    if (rdata !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL rdata_hold: got %h, want a5", rdata);
    end
    rr_ptr = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] prev_a;
    logic prev_busy;
    logic cl;
    logic [ADDR_W-1:0] a;
    int done0 = 0, done1 = 0, acks = 0;
    use_model = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cl = (k % 2 == 1) ? ~rr_ptr : rr_ptr;
      a = (cl ? 24'h000310 : 24'h000300) + ADDR_W'(k / 2);
      sb.push_back('{client: cl, is_rd: 1'b1, rdata: a[7:0] ^ 8'h5A, err: 1'b0});
    end
    addr0 = 24'h000300;
    addr1 = 24'h000310;
    we0 = 1'b0;
    we1 = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    prev_a = nf_a;
    prev_busy = busy;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge clk_f);
      total++;
      if (nf_a !== prev_a && prev_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL addr_switch: got %h from %h outside grant", nf_a, prev_a);
      end
      if (ack0 === 1'b1) begin
        acks++;
        done0++;
        addr0 = 24'h000300 + ADDR_W'(done0);
        if (done0 == 2) req0 = 1'b0;
      end
      if (ack1 === 1'b1) begin
        acks++;
        done1++;
        addr1 = 24'h000310 + ADDR_W'(done1);
        if (done1 == 2) req1 = 1'b0;
      end
      prev_a = nf_a;
      prev_busy = busy;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    total++;
    if (acks !== 4) begin
      bad++;
      $display("[TB] FAIL alternate_count: got %0d acks, want 4", acks);
    end
    use_model = 1'b0;
    @(negedge clk_f);
  endtask

  task automatic test_write();
    int we_low = 0, ack_at = 0;
    logic data_bad = 1'b0, doe_bad = 1'b0;
    nf_sts = 1'b0;
    addr0 = 24'h000010;
    wdata0 = 8'h3C;
    we0 = 1'b1;
    req0 = 1'b1;
    sb.push_back('{client: 1'b0, is_rd: 1'b0, rdata: 8'h00, err: 1'b0});
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_f);
      if (i == 10) nf_sts = 1'b1;
      if (nf_we === 1'b0) begin
        we_low++;
        if (nf_d_oe !== 1'b1 || nf_d_out !== 8'h3C || nf_ce !== 1'b0) data_bad = 1'b1;
      end
      if (nf_ce === 1'b1 && nf_d_oe === 1'b1) doe_bad = 1'b1;
      if (ack0 === 1'b1) begin
        ack_at = i;
        break;
      end
    end
    req0 = 1'b0;
    we0 = 1'b0;
    total++;
    if (we_low !== T_WP) begin
      bad++;
      $display("[TB] FAIL write_we_width: got %0d, want %0d", we_low, T_WP);
    end
    total++;
    if (data_bad !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_data: got bad=%b, want 0 (d_oe=1, data 3c)", data_bad);
    end
    total++;
    if (doe_bad !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_doe_release: got bad=%b, want 0", doe_bad);
    end
    total++;
    if (ack_at < 11 || ack_at > 16) begin
      bad++;
      $display("[TB] FAIL write_ack_time: got cycle %0d, want 11..16", ack_at);
    end
    rr_ptr = 1'b1;
    @(negedge clk_f);
  endtask

  task automatic test_timeout();
    int entry = 0, ack_at = 0, n = 0;
    logic seen_we = 1'b0;
    nf_sts = 1'b0;
    addr1 = 24'h000020;
    wdata1 = 8'h77;
    we1 = 1'b1;
    req1 = 1'b1;
    sb.push_back('{client: 1'b1, is_rd: 1'b0, rdata: 8'h00, err: 1'b1});
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_f);
      if (nf_we === 1'b0) seen_we = 1'b1;
      if (seen_we && entry == 0 && nf_ce === 1'b1) entry = i;
      if (ack1 === 1'b1) begin
        ack_at = i;
        break;
      end
    end
    req1 = 1'b0;
    we1 = 1'b0;
    total++;
    if (ack_at == 0 || ack_at - entry !== BUSY_TIMEOUT) begin
      bad++;
      $display("[TB] FAIL timeout_latency: got %0d (ack %0d entry %0d), want %0d",
               ack_at - entry, ack_at, entry, BUSY_TIMEOUT);
    end
    @(negedge clk_f);
    flash_byte = 8'h96;
    addr0 = 24'h0000AA;
    we0 = 1'b0;
    req0 = 1'b1;
    sb.push_back('{client: 1'b0, is_rd: 1'b1, rdata: 8'h96, err: 1'b0});
    while (ack0 !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk_f);
    end
    req0 = 1'b0;
    total++;
    if (n !== T_RD + 1) begin
      bad++;
      $display("[TB] FAIL read_after_timeout: got latency %0d, want %0d", n, T_RD + 1);
    end
    rr_ptr = 1'b1;
    @(negedge clk_f);
  endtask

  task automatic test_reset_abort();
    logic [5:0] pins;
    logic found = 1'b0, ack_seen = 1'b0;
    int hold = 0;
    addr1 = 24'h000040;
    wdata1 = 8'h99;
    we1 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_f);
      if (nf_we === 1'b0) found = 1'b1;
    end
    total++;
    if (found !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_reach_pulse: got %b, want 1", found);
    end
    rst = 1'b1;
    #1;
    pins = {nf_we, nf_ce, nf_d_oe, nf_rp, ack0, ack1};
    total++;
    if (pins !== 6'b110000) begin
      bad++;
      $display("[TB] FAIL abort_pins: got %b, want 110000", pins);
    end
    req1 = 1'b0;
    we1 = 1'b0;
    repeat (2) @(negedge clk_f);
    rst = 1'b0;
    while (nf_rp === 1'b0 && hold < 200) begin
      hold++;
      if (ack0 === 1'b1 || ack1 === 1'b1) ack_seen = 1'b1;
      @(negedge clk_f);
    end
    repeat (10) begin
      if (ack0 === 1'b1 || ack1 === 1'b1) ack_seen = 1'b1;
      @(negedge clk_f);
    end
    total++;
    if (hold !== RP_CYCLES) begin
      bad++;
      $display("[TB] FAIL abort_rp_hold: got %0d, want %0d", hold, RP_CYCLES);
    end
    total++;
    if (ack_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_ack: got %b, want 0", ack_seen);
    end
    rr_ptr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_write();
    test_timeout();
    test_reset_abort();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
